// File: rtl/ifconv_sched.sv
// Two-port round-robin issue scheduler for the shared int-to-float convert unit.
// Shadows the unit's two clkEn-gated stages with {vld, tag, port} and stalls on output backpressure.
module ifconv_sched #(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_vld,
  output logic             req0_rdy,
  input  logic [63:0]      req0_A,
  input  logic             req0_isS,
  input  logic [1:0]       req0_fmt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_vld,
  output logic             req1_rdy,
  input  logic [63:0]      req1_A,
  input  logic             req1_isS,
  input  logic [1:0]       req1_fmt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             cv_en,
  output logic             cv_clkEn,
  output logic [63:0]      cv_A,
  output logic             cv_isS,
  output logic             cv_toSNG,
  output logic             cv_toDBL,
  output logic             cv_toEXT,
  input  logic [81:0]      cv_res,
  input  logic [1:0]       cv_rtyp,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [81:0]      out_res,
  output logic [1:0]       out_rtyp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_port,
  output logic             err_illegal
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             port;
  } ent_t;

  ent_t       s1_q, s1_d, s2_q, s2_d;
  logic       rr_q, rr_d, err_q, err_d;
  logic       adv, e0, e1, gnt, win, legal;
  logic [1:0] fmt_w;

  always_comb begin
    adv   = !s2_q.vld || out_rdy;
    e0    = req0_vld && adv && !flush && rst;
    e1    = req1_vld && adv && !flush && rst;
    gnt   = e0 || e1;
    // rr names the winner only under contention; a lone requester always wins
    win   = (e0 && e1) ? rr_q : e1;
    rr_d  = (e0 && e1) ? ~rr_q : rr_q;
    fmt_w = win ? req1_fmt : req0_fmt;
    legal = gnt && (fmt_w != 2'b00);

    req0_rdy = gnt && !win;
    req1_rdy = gnt && win;
    cv_en    = legal;
    cv_clkEn = adv || flush || !rst;
    cv_A     = win ? req1_A : req0_A;
    cv_isS   = win ? req1_isS : req0_isS;
    cv_toSNG = legal && (fmt_w == 2'b01);
    cv_toDBL = legal && (fmt_w == 2'b10);
    cv_toEXT = legal && (fmt_w == 2'b11);

    s1_d = s1_q;
    s2_d = s2_q;
    if (adv) begin
      s2_d     = s1_q;
      s1_d.vld  = legal;
      s1_d.tag  = win ? req1_tag : req0_tag;
      s1_d.port = win;
    end
    if (flush) begin
      s1_d.vld = 1'b0;
      s2_d.vld = 1'b0;
    end
    err_d = gnt && !legal;

    out_vld  = s2_q.vld && rst;
    out_tag  = s2_q.tag;
    out_port = s2_q.port;
    out_res  = cv_res;
    out_rtyp = cv_rtyp;
    err_illegal = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q.vld <= 1'b0;
      s2_q.vld <= 1'b0;
      rr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_ifconv_sched.sv
// Bench for ifconv_sched: a stand-in convert unit plus a request/delivery reference model.
module tb_ifconv_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, flush = 1'b0, out_rdy = 1'b1;
  logic req0_vld = 1'b0, req1_vld = 1'b0, req0_isS = 1'b0, req1_isS = 1'b0;
  logic [63:0] req0_A = '0, req1_A = '0;
  logic [1:0] req0_fmt = 2'b0, req1_fmt = 2'b0;
  logic [8:0] req0_tag = '0, req1_tag = '0;
  logic req0_rdy, req1_rdy, cv_en, cv_clkEn, cv_isS, cv_toSNG, cv_toDBL, cv_toEXT;
  logic out_vld, out_port, err_illegal;
  logic [63:0] cv_A;
  logic [81:0] cv_res, out_res;
  logic [1:0] cv_rtyp, out_rtyp;
  logic [8:0] out_tag;

  ifconv_sched #(.TAG_W(9)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_A(req0_A), .req0_isS(req0_isS),
    .req0_fmt(req0_fmt), .req0_tag(req0_tag),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_A(req1_A), .req1_isS(req1_isS),
    .req1_fmt(req1_fmt), .req1_tag(req1_tag),
    .cv_en(cv_en), .cv_clkEn(cv_clkEn), .cv_A(cv_A), .cv_isS(cv_isS),
    .cv_toSNG(cv_toSNG), .cv_toDBL(cv_toDBL), .cv_toEXT(cv_toEXT),
    .cv_res(cv_res), .cv_rtyp(cv_rtyp),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_rtyp(out_rtyp),
    .out_tag(out_tag), .out_port(out_port), .err_illegal(err_illegal)
  );

  // Stand-in convert unit: two clkEn-gated stages, result is a fixed function of the operand.
  logic [63:0] u1A, u2A;
  logic        u1S, u2S;
  logic [2:0]  u1F, u2F;
  always @(posedge clk) if (cv_clkEn) begin
    u1A <= cv_A; u1S <= cv_isS; u1F <= {cv_toSNG, cv_toDBL, cv_toEXT};
    u2A <= u1A;  u2S <= u1S;    u2F <= u1F;
  end
  assign cv_res  = {u2A[17:0] ^ {17'b0, u2S}, u2A};
  assign cv_rtyp = u2F[2] ? 2'd1 : u2F[1] ? 2'd2 : u2F[0] ? 2'd3 : 2'd0;

  typedef struct packed {
    logic vld; logic [8:0] tag; logic port; logic [63:0] A; logic isS; logic [1:0] fmt;
  } m_t;

  m_t m_s1 = '0, m_s2 = '0;
  logic m_rr = 1'b0, m_err = 1'b0;
  logic [9:0] sb_q[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [81:0] got, input logic [81:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] f);
    return (f == 2'd1) ? 3'b100 : (f == 2'd2) ? 3'b010 : (f == 2'd3) ? 3'b001 : 3'b000;
  endfunction

  // One clock: check settled outputs at the falling edge, then advance the model at the rising edge.
  task automatic cyc();
    logic adv, e0, e1, w, g, lg;
    logic [9:0] hd;
    m_t nw;
    @(negedge clk);
    adv = !m_s2.vld || out_rdy;
    e0 = req0_vld && adv && !flush && rst;
    e1 = req1_vld && adv && !flush && rst;
    g  = e0 || e1;
    w  = (e0 && e1) ? m_rr : e1;
    nw = w ? '{1'b1, req1_tag, 1'b1, req1_A, req1_isS, req1_fmt}
           : '{1'b1, req0_tag, 1'b0, req0_A, req0_isS, req0_fmt};
    lg = g && (nw.fmt != 2'd0);
    nw.vld = lg;
    chk("rdy0", req0_rdy, g && !w);
    chk("rdy1", req1_rdy, g && w);
    chk("clkEn", cv_clkEn, adv || flush || !rst);
    chk("cv_en", cv_en, lg);
    chk("onehot", {cv_toSNG, cv_toDBL, cv_toEXT}, lg ? oh(nw.fmt) : 3'b000);
    chk("out_vld", out_vld, m_s2.vld && rst);
    chk("err_illegal", err_illegal, m_err);
    if (lg) begin
      chk("cv_A", cv_A, nw.A);
      chk("cv_isS", cv_isS, nw.isS);
    end
    if (m_s2.vld && rst) begin
      chk("out_tag", out_tag, m_s2.tag);
      chk("out_port", out_port, m_s2.port);
      chk("out_res", out_res, {m_s2.A[17:0] ^ {17'b0, m_s2.isS}, m_s2.A});
      chk("out_rtyp", out_rtyp, m_s2.fmt);
    end
    if (out_vld && out_rdy) begin
      if (sb_q.size() == 0) chk("deliver_extra", 1'b1, 1'b0);
      else begin
        hd = sb_q.pop_front();
        chk("deliver_order", {out_port, out_tag}, hd);
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_s1.vld = 1'b0; m_s2.vld = 1'b0; m_rr = 1'b0; m_err = 1'b0; sb_q.delete();
    end else if (flush) begin
      m_s1.vld = 1'b0; m_s2.vld = 1'b0; m_err = 1'b0; sb_q.delete();
    end else begin
      m_err = g && !lg;
      if (e0 && e1) m_rr = ~m_rr;
      if (adv) begin
        m_s2 = m_s1;
        m_s1 = nw;
        if (lg) sb_q.push_back({nw.port, nw.tag});
      end
    end
    #1;
  endtask

  task automatic idle();
    req0_vld = 1'b0; req1_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
  endtask

  initial begin
    // reset
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    // single conversion: port 0, DBL, tag 5
    req0_vld = 1'b1; req0_fmt = 2'b10; req0_tag = 9'd5; req0_A = 64'h1234_5678_9abc_def0; req0_isS = 1'b1;
    cyc();
    idle(); cyc(); cyc(); cyc();
    // contention: alternating grants from reset pointer
    for (int i = 0; i < 4; i++) begin
      req0_vld = 1'b1; req0_tag = 9'(1 + i);  req0_fmt = 2'b01; req0_A = 64'(i * 3 + 1);
      req1_vld = 1'b1; req1_tag = 9'(11 + i); req1_fmt = 2'b11; req1_A = 64'(i * 7 + 100);
      cyc();
    end
    idle(); cyc(); cyc(); cyc();
    // stall with tags 7 and 8 in flight
    req0_vld = 1'b1; req0_tag = 9'd7; req0_fmt = 2'b10; req0_A = 64'hAAAA; cyc();
    req0_tag = 9'd8; req0_A = 64'hBBBB; cyc();
    req0_vld = 1'b0; out_rdy = 1'b0;
    cyc(); cyc(); cyc();
    out_rdy = 1'b1; cyc(); cyc(); cyc();
    // illegal fmt on port 1 against a legal port 0 request
    req0_vld = 1'b1; req0_fmt = 2'b01; req0_tag = 9'd20;
    req1_vld = 1'b1; req1_fmt = 2'b00; req1_tag = 9'd9;
    cyc(); cyc();
    idle(); cyc(); cyc(); cyc();
    // flush with both stages valid, then a fresh request
    req0_vld = 1'b1; req0_fmt = 2'b11; req0_tag = 9'd30; cyc();
    req0_tag = 9'd31; cyc();
    flush = 1'b1; cyc();
    flush = 1'b0; req0_tag = 9'd32; cyc();
    idle(); cyc(); cyc(); cyc();
    // reset with two ops in flight, then contested grant
    req0_vld = 1'b1; req0_tag = 9'd40; cyc();
    req0_tag = 9'd41; cyc();
    idle(); rst = 1'b0; cyc(); cyc();
    rst = 1'b1; req0_vld = 1'b1; req1_vld = 1'b1; req1_fmt = 2'b10; cyc();
    idle(); cyc(); cyc(); cyc();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      req0_vld = $urandom_range(0, 3) != 0;  req1_vld = $urandom_range(0, 3) != 0;
      req0_A = {$urandom, $urandom};         req1_A = {$urandom, $urandom};
      req0_isS = $urandom_range(0, 1) == 1;  req1_isS = $urandom_range(0, 1) == 1;
      req0_fmt = 2'($urandom_range(0, 3));   req1_fmt = 2'($urandom_range(0, 3));
      req0_tag = 9'($urandom);               req1_tag = 9'($urandom);
      out_rdy = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 63) != 0;
      cyc();
    end
    rst = 1'b1; idle(); cyc(); cyc(); cyc();
    chk("drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
